// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control sequencer
//
// Holds the opcode constants, the 4-bit sequencer state enumeration, the
// opcode class enumeration, the ALUOp codes (single-cycle encoding) and the
// datapath mux select codes. imm_alu_op maps an I-type ALU opcode to its ALUOp.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        R_EXEC    = 4'd7,
        I_EXEC    = 4'd8,
        ALU_WB    = 4'd9,
        BRANCH    = 4'd10,
        JUMP      = 4'd11,
        JAL       = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        CLS_MEM     = 3'd0,
        CLS_R       = 3'd1,
        CLS_IMM     = 3'd2,
        CLS_BR      = 3'd3,
        CLS_J       = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } opClass_t;

    localparam logic [3:0] ALU_R    = 4'b0000;
    localparam logic [3:0] ALU_ADDI = 4'b0001;
    localparam logic [3:0] ALU_ORI  = 4'b0010;
    localparam logic [3:0] ALU_LUI  = 4'b0011;
    localparam logic [3:0] ALU_ANDI = 4'b0100;
    localparam logic [3:0] ALU_BEQ  = 4'b0101;
    localparam logic [3:0] ALU_BNE  = 4'b0110;
    localparam logic [3:0] ALU_ADD  = 4'b0111;
    localparam logic [3:0] ALU_SW   = 4'b1000;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ADDI: imm_alu_op = ALU_ADDI;
            OP_ORI:  imm_alu_op = ALU_ORI;
            OP_LUI:  imm_alu_op = ALU_LUI;
            OP_ANDI: imm_alu_op = ALU_ANDI;
            default: imm_alu_op = ALU_ADDI;
        endcase
    endfunction

endpackage

// File: rtl/opcode_class.sv
// rtl/opcode_class.sv - combinational opcode to instruction-class decode
//
// Ports:
//   OP       in  6  opcode
//   opClass  out 3  opClass_t code (MEM, R, IMM, BR, J, JAL, ILLEGAL)
module opcode_class
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] OP,
    output logic [2:0] opClass
);

    always_comb begin
        opClass = CLS_ILLEGAL;
        case (OP)
            OP_LW, OP_SW:                     opClass = CLS_MEM;
            OP_RTYPE:                         opClass = CLS_R;
            OP_ADDI, OP_ORI, OP_LUI, OP_ANDI: opClass = CLS_IMM;
            OP_BEQ, OP_BNE:                   opClass = CLS_BR;
            OP_J:                             opClass = CLS_J;
            OP_JAL:                           opClass = CLS_JAL;
            default:                          opClass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore sequencer driving the multi-cycle MIPS datapath
//
// Optional feature macro: MULTICYCLE_CTRL_MEM_WAIT_EN adds the mem_ready port;
// FETCH, MEM_READ and MEM_WRITE then hold until mem_ready=1.
//
// Ports:
//   clk, reset (async active-low), OP (opcode, sampled in DECODE),
//   mem_ready (wait build only),
//   PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite,
//   RegDst[1:0], MemtoReg[1:0], RegWrite, ALUSrcA, ALUSrcB[1:0],
//   PCSource[1:0], ALUOp[3:0], instr_done, illegal_op, state[3:0] (debug)
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       PCWrite,
    output logic       BranchEQ,
    output logic       BranchNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOp,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t     cur;
    state_t     nxt;
    logic [5:0] op_q;
    logic [2:0] opCls;
    logic       memOk;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    assign memOk = mem_ready;
`else
    assign memOk = 1'b1;
`endif

    opcode_class u_opcode_class (
        .OP      (OP),
        .opClass (opCls)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur  <= IDLE;
            op_q <= 6'h00;
        end else begin
            cur <= nxt;
            if (cur == DECODE) begin
                op_q <= OP;
            end
        end
    end

    always_comb begin
        nxt        = cur;
        PCWrite    = 1'b0;
        BranchEQ   = 1'b0;
        BranchNE   = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = REGDST_RT;
        MemtoReg   = M2R_ALUOUT;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RT;
        PCSource   = PCSRC_ALU;
        ALUOp      = ALU_R;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (cur)
            IDLE: nxt = FETCH;
            FETCH: begin
                // The memory read is held for the whole wait; the IR and PC
                // only load in the cycle the data is actually valid.
                MemRead = 1'b1;
                IRWrite = memOk;
                PCWrite = memOk;
                ALUSrcB = SRCB_FOUR;
                ALUOp   = ALU_ADD;
                nxt     = memOk ? DECODE : FETCH;
            end
            DECODE: begin
                // PC + (imm << 2) lands in ALUOut for a possible branch.
                ALUSrcB = SRCB_IMMSH;
                ALUOp   = ALU_ADD;
                case (opCls)
                    CLS_MEM: nxt = MEM_ADDR;
                    CLS_R:   nxt = R_EXEC;
                    CLS_IMM: nxt = I_EXEC;
                    CLS_BR:  nxt = BRANCH;
                    CLS_J:   nxt = JUMP;
                    CLS_JAL: nxt = JAL;
                    default: begin
                        nxt        = FETCH;
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALU_ADD;
                nxt     = (op_q == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                nxt     = memOk ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                MemtoReg   = M2R_MDR;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            MEM_WRITE: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = memOk;
                nxt        = memOk ? FETCH : MEM_WRITE;
            end
            R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_R;
                nxt     = ALU_WB;
            end
            I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = imm_alu_op(op_q);
                nxt     = ALU_WB;
            end
            ALU_WB: begin
                RegDst     = (op_q == OP_RTYPE) ? REGDST_RD : REGDST_RT;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                PCSource   = PCSRC_ALUOUT;
                instr_done = 1'b1;
                if (op_q == OP_BNE) begin
                    ALUOp    = ALU_BNE;
                    BranchNE = 1'b1;
                end else begin
                    ALUOp    = ALU_BEQ;
                    BranchEQ = 1'b1;
                end
                nxt = FETCH;
            end
            JUMP: begin
                PCSource   = PCSRC_JUMP;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            JAL: begin
                // Register file writes PC+4 (current PC) on the same edge the PC loads.
                PCSource   = PCSRC_JUMP;
                PCWrite    = 1'b1;
                RegDst     = REGDST_RA;
                MemtoReg   = M2R_PC;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            default: nxt = IDLE;
        endcase
    end

    assign state = cur;

endmodule
